// File: rtl/bias_out_writer.sv
// bias_out_writer: collects the 16-lane fp32 result stream of the bias/ReLU6
// stage into a small FIFO and writes it to the output feature-map buffer
// through a valid/ready port with linear addressing. The upstream cannot
// stall, so vectors arriving while the FIFO is full are dropped and flagged.
module bias_out_writer #(
   parameter int BANDWIDTH  = 512,
   parameter int BITWIDTH   = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 16
) (
   input  logic                            clk_calc,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [ADDR_W-1:0]               base_addr,
   input  logic [ADDR_W-1:0]               pix_num,
   input  logic                            data_in_vld,
   input  logic [BITWIDTH*(BANDWIDTH/BITWIDTH)-1:0] data_in,
   input  logic                            wr_ready,
   output logic                            wr_en,
   output logic [ADDR_W-1:0]               wr_addr,
   output logic [BITWIDTH*(BANDWIDTH/BITWIDTH)-1:0] wr_data,
   output logic                            busy,
   output logic                            done,
   output logic                            ovf_err
);

   localparam int VW = BITWIDTH * (BANDWIDTH / BITWIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pix;
   logic [ADDR_W-1:0] r_in_cnt;
   logic [ADDR_W-1:0] r_next_addr;
   logic              r_ovf;

   logic [VW-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [VW-1:0]     r_wr_data;

   logic w_full;
   logic w_empty;
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_xfer;
   logic w_start;
   logic w_drained;

   assign w_full    = (r_count == FULL_LVL);
   assign w_empty   = (r_count == '0);
   assign w_start   = (r_state == S_IDLE) && start;
   assign w_accept  = (r_state == S_RUN) && data_in_vld && (r_in_cnt < r_pix);
   // Full is judged on the pre-edge occupancy; a same-cycle pop does not help.
   assign w_push    = w_accept && !w_full;
   assign w_xfer    = r_wr_en && wr_ready;
   assign w_pop     = !w_empty && (!r_wr_en || wr_ready);
   // Nothing buffered and the output register is empty or emptying this edge,
   // so DONE lands in the cycle right after the final beat.
   assign w_drained = w_empty && (!r_wr_en || wr_ready);

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign ovf_err = r_ovf;

   // Pass control: state sequencing, parameter capture, input count, overflow flag.
   always_ff @(posedge clk_calc or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_pix    <= '0;
         r_in_cnt <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pix    <= pix_num;
                  r_in_cnt <= '0;
                  r_ovf    <= 1'b0;
                  r_state  <= (pix_num == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (r_in_cnt == r_pix) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_drained) r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_accept) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (w_full) r_ovf <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk_calc) begin
      if (w_push) r_mem[r_wptr] <= data_in;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_calc or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output register: reload from the FIFO head when free or transferring, hold on stall.
   always_ff @(posedge clk_calc or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_next_addr <= '0;
      end else begin
         if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_next_addr;
            r_wr_data <= r_mem[r_rptr];
         end else if (w_xfer) begin
            r_wr_en   <= 1'b0;
         end
         // Addresses are handed out at load time, so dropped vectors take none.
         if (w_start) begin
            r_next_addr <= base_addr;
         end else if (w_pop) begin
            r_next_addr <= r_next_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bias_out_writer.sv
// Self-checking bench for bias_out_writer: directed scenarios plus randomized
// passes compared against a transaction-level model (expected beat list).
module tb_bias_out_writer;

   localparam int AW = 16;
   localparam int VW = 512;

   logic          clk_calc = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] pix_num   = '0;
   logic          data_in_vld = 1'b0;
   logic [VW-1:0] data_in   = '0;
   logic          wr_ready  = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [VW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          ovf_err;

   bias_out_writer #(
      .BANDWIDTH (512),
      .BITWIDTH  (32),
      .FIFO_DEPTH(8),
      .ADDR_W    (16)
   ) dut (
      .clk_calc   (clk_calc),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .pix_num    (pix_num),
      .data_in_vld(data_in_vld),
      .data_in    (data_in),
      .wr_ready   (wr_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .ovf_err    (ovf_err)
   );

   always #5 clk_calc = ~clk_calc;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk_calc) cyc <= cyc + 1;

   // Monitor (negedge): observed beats, done pulses, stall stability.
   logic [AW-1:0] q_addr[$];
   logic [VW-1:0] q_data[$];
   int            q_cyc[$];
   int            done_cnt, done_cyc, first_cyc, wren_cnt, stall_viol;
   bit            first_seen, prev_stall;
   logic [AW-1:0] p_addr;
   logic [VW-1:0] p_data;

   always @(negedge clk_calc) begin
      if (rst_n) begin
         if (wr_en && !first_seen) begin
            first_seen = 1'b1;
            first_cyc  = cyc;
         end
         if (wr_en) wren_cnt++;
         if (prev_stall && (!wr_en || wr_addr !== p_addr || wr_data !== p_data)) stall_viol++;
         prev_stall = wr_en && !wr_ready;
         p_addr = wr_addr;
         p_data = wr_data;
         if (wr_en && wr_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            q_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clear_mon();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      done_cnt = 0; done_cyc = -1; first_cyc = -1; wren_cnt = 0; stall_viol = 0;
      first_seen = 1'b0; prev_stall = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_calc);
      #1;
   endtask

   function automatic logic [VW-1:0] lane_vec(input logic [31:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Pulse start in the current cycle; returns the start cycle.
   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n, output int s);
      base_addr = b;
      pix_num   = n;
      start     = 1'b1;
      s         = cyc;
      tick();
      start     = 1'b0;
   endtask

   // Wait for done (bounded); on exit we are in the cycle after done.
   task automatic wait_done(input int max_cyc, input bit rnd_ready, input string tag);
      int k = 0;
      while (done_cnt == 0 && k < max_cyc) begin
         if (rnd_ready) wr_ready = ($urandom_range(0, 9) < 7);
         tick();
         k++;
      end
      n_vec++;
      if (done_cnt == 0) begin
         n_err++;
         $display("FAIL %s_done_timeout: got no done after %0d cycles, want done", tag, max_cyc);
      end
      wr_ready = 1'b1;
   endtask

   // Compare observed beats with the expected list: addr = base + index.
   task automatic check_beats(input logic [VW-1:0] exp_q[$], input logic [AW-1:0] b,
                              input string tag);
      n_vec++;
      if (q_addr.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s_beat_count: got %0d, want %0d", tag, q_addr.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < q_addr.size(); i++) begin
         logic [AW-1:0] ea;
         ea = b + AW'(i);
         n_vec++;
         if (q_addr[i] !== ea || q_data[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s_beat%0d: got addr %h data[31:0] %h, want addr %h data[31:0] %h",
                     tag, i, q_addr[i], q_data[i][31:0], ea, exp_q[i][31:0]);
         end
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if ({wr_en, busy, done, ovf_err} !== 4'b0 || wr_addr !== '0 || wr_data !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got en/busy/done/ovf %b%b%b%b addr %h, want 0000 addr 0000",
                  wr_en, busy, done, ovf_err, wr_addr);
      end
   endtask

   task automatic test_basic();
      logic [VW-1:0] exp_q[$];
      int s, v0;
      clear_mon();
      wr_ready = 1'b1;
      pulse_start(16'h0100, 16'd4, s);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy: got %b, want 1", busy);
      end
      v0 = cyc;
      for (int k = 1; k <= 4; k++) begin
         data_in_vld = 1'b1;
         data_in     = lane_vec(32'(k));
         exp_q.push_back(data_in);
         tick();
      end
      data_in_vld = 1'b0;
      wait_done(40, 1'b0, "basic");
      check_beats(exp_q, 16'h0100, "basic");
      n_vec++;
      if (first_cyc != v0 + 2) begin
         n_err++;
         $display("FAIL basic_latency: got first wr_en cycle %0d, want %0d", first_cyc, v0 + 2);
      end
      n_vec++;
      if (q_cyc.size() == 0 || done_cyc != q_cyc[q_cyc.size()-1] + 1) begin
         n_err++;
         $display("FAIL basic_done_cycle: got %0d, want last beat + 1", done_cyc);
      end
      n_vec++;
      if (busy !== 1'b0 || ovf_err !== 1'b0) begin
         n_err++;
         $display("FAIL basic_end_flags: got busy %b ovf %b, want 0 0", busy, ovf_err);
      end
   endtask

   task automatic test_overflow();
      logic [VW-1:0] all_q[$];
      logic [VW-1:0] exp_q[$];
      int s;
      clear_mon();
      wr_ready = 1'b0;
      pulse_start(16'h2000, 16'd12, s);
      for (int k = 0; k < 12; k++) begin
         data_in_vld = 1'b1;
         data_in     = rnd_vec();
         all_q.push_back(data_in);
         tick();
      end
      data_in_vld = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (ovf_err !== 1'b1 || wr_en !== 1'b1 || q_addr.size() != 0) begin
         n_err++;
         $display("FAIL ovf_hold: got ovf %b wr_en %b beats %0d, want 1 1 0",
                  ovf_err, wr_en, q_addr.size());
      end
      // FIFO_DEPTH buffered plus one in the output register survive.
      for (int i = 0; i < 9; i++) exp_q.push_back(all_q[i]);
      wr_ready = 1'b1;
      wait_done(60, 1'b0, "ovf");
      check_beats(exp_q, 16'h2000, "ovf");
      n_vec++;
      if (ovf_err !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sticky: got %b, want 1", ovf_err);
      end
   endtask

   task automatic test_stall();
      logic [VW-1:0] exp_q[$];
      int s, k;
      clear_mon();
      wr_ready = 1'b1;
      pulse_start(16'h0300, 16'd6, s);
      k = 0;
      for (int i = 0; i < 6; i++) begin
         wr_ready    = (k % 3 == 0);
         data_in_vld = 1'b1;
         data_in     = rnd_vec();
         exp_q.push_back(data_in);
         tick();
         k++;
      end
      data_in_vld = 1'b0;
      while (done_cnt == 0 && k < 80) begin
         wr_ready = (k % 3 == 0);
         tick();
         k++;
      end
      wr_ready = 1'b1;
      wait_done(10, 1'b0, "stall");
      check_beats(exp_q, 16'h0300, "stall");
      n_vec++;
      if (stall_viol != 0 || ovf_err !== 1'b0) begin
         n_err++;
         $display("FAIL stall_stable: got %0d unstable stalls ovf %b, want 0 0", stall_viol, ovf_err);
      end
   endtask

   task automatic test_wrap();
      logic [VW-1:0] exp_q[$];
      int s;
      clear_mon();
      pulse_start(16'hFFFE, 16'd4, s);
      for (int i = 0; i < 4; i++) begin
         data_in_vld = 1'b1;
         data_in     = rnd_vec();
         exp_q.push_back(data_in);
         tick();
      end
      data_in_vld = 1'b0;
      wait_done(40, 1'b0, "wrap");
      check_beats(exp_q, 16'hFFFE, "wrap");
   endtask

   task automatic test_zero_and_ignore();
      logic [VW-1:0] exp_q[$];
      int s;
      clear_mon();
      pulse_start(16'h0700, 16'd0, s);
      wait_done(5, 1'b0, "zero");
      n_vec++;
      if (done_cyc != s + 1 || wren_cnt != 0) begin
         n_err++;
         $display("FAIL zero_pass: got done cycle %0d wr_en cycles %0d, want %0d 0",
                  done_cyc, wren_cnt, s + 1);
      end
      clear_mon();
      pulse_start(16'h0200, 16'd3, s);
      for (int i = 0; i < 5; i++) begin
         // Second start while busy must be ignored; vectors 4 and 5 exceed the count.
         start       = (i == 0);
         base_addr   = 16'h0500;
         pix_num     = 16'd7;
         data_in_vld = 1'b1;
         data_in     = rnd_vec();
         if (i < 3) exp_q.push_back(data_in);
         tick();
      end
      start       = 1'b0;
      data_in_vld = 1'b1;
      data_in     = rnd_vec();
      tick();
      data_in_vld = 1'b0;
      wait_done(40, 1'b0, "ignore");
      check_beats(exp_q, 16'h0200, "ignore");
      repeat (4) tick();
      n_vec++;
      if (wr_en !== 1'b0 || done_cnt != 1) begin
         n_err++;
         $display("FAIL ignore_after: got wr_en %b done pulses %0d, want 0 1", wr_en, done_cnt);
      end
   endtask

   task automatic test_random(input int iters);
      for (int it = 0; it < iters; it++) begin
         logic [VW-1:0] exp_q[$];
         logic [AW-1:0] b;
         int n, sent, s, k;
         // At most FIFO_DEPTH+1 vectors per pass, so nothing can be dropped.
         clear_mon();
         b = AW'($urandom);
         n = $urandom_range(1, 9);
         pulse_start(b, AW'(n), s);
         sent = 0;
         k = 0;
         while (sent < n && k < 200) begin
            wr_ready    = ($urandom_range(0, 9) < 7);
            data_in_vld = ($urandom_range(0, 9) < 6);
            data_in     = rnd_vec();
            if (data_in_vld) begin
               exp_q.push_back(data_in);
               sent++;
            end
            tick();
            k++;
         end
         data_in_vld = 1'b0;
         wait_done(200, 1'b1, "rnd");
         check_beats(exp_q, b, "rnd");
         n_vec++;
         if (ovf_err !== 1'b0 || stall_viol != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL rnd_flags: got ovf %b unstable %0d done %0d, want 0 0 1",
                     ovf_err, stall_viol, done_cnt);
         end
         tick();
      end
   endtask

   task automatic test_reset_midpass();
      int s;
      clear_mon();
      wr_ready = 1'b0;
      pulse_start(16'h0040, 16'd8, s);
      for (int i = 0; i < 4; i++) begin
         data_in_vld = 1'b1;
         data_in     = rnd_vec();
         tick();
      end
      data_in_vld = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({wr_en, busy, done, ovf_err} !== 4'b0 || wr_addr !== '0 || wr_data !== '0) begin
         n_err++;
         $display("FAIL midpass_reset: got en/busy/done/ovf %b%b%b%b addr %h, want 0000 0000",
                  wr_en, busy, done, ovf_err, wr_addr);
      end
      wr_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      test_basic();
   endtask

   initial begin
      clear_mon();
      rst_n = 1'b0;
      repeat (2) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_basic();
      test_overflow();
      test_stall();
      test_wrap();
      test_zero_and_ignore();
      test_random(25);
      test_reset_midpass();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
